// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULU  = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } muldiv_state_t;

    function automatic logic is_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_acc(input muldiv_op_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_sub(input muldiv_op_t op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One datapath iteration: a STEP-bit partial-product accumulate, or one restoring divide step.
module muldiv_core_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   work_i,
    input  logic [2*WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   work_o,
    output logic [2*WIDTH-1:0]   mcand_o,
    output logic [WIDTH-1:0]     mplier_o
);

    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   digit;

    always_comb begin
        work_o   = work_i;
        mcand_o  = mcand_i;
        mplier_o = mplier_i;
        rem_sh   = '0;
        diff     = '0;
        digit    = '0;
        if (is_div) begin
            // work holds {rem, quo}; rem_sh is the remainder after shifting in the next dividend bit
            rem_sh = work_i[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh - {1'b0, mcand_i[WIDTH-1:0]};
            if (rem_sh >= {1'b0, mcand_i[WIDTH-1:0]}) begin
                work_o = {diff[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
            end else begin
                work_o = {work_i[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            digit[STEP-1:0] = mplier_i[STEP-1:0];
            work_o   = work_i + mcand_i * digit;
            mcand_o  = mcand_i << STEP;
            mplier_o = mplier_i >> STEP;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage; results build in shadow registers
// and are committed to HI/LO in one cycle so a flush never leaves partial state.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] source_a,
    input  logic [WIDTH-1:0] source_b,
    input  logic             reg_stall,
    input  logic             flush,
    output logic             alu_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] hi_write_data,
    input  logic [WIDTH-1:0] lo_write_data
);
    import muldiv_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op_q, op_d, op_in;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, work_q, work_d, mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, a_neg_q, a_neg_d;

    logic               in_signed;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fix_hi, fix_lo, step_mplier;
    logic [2*WIDTH-1:0] step_work, step_mcand, prod_fix, mul_res;

    muldiv_core_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .is_div   (state_q == S_DIV),
        .work_i   (work_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .work_o   (step_work),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier)
    );

    assign op_in     = muldiv_op_t'(op);
    assign in_signed = is_signed(op_in);
    assign mag_a     = (in_signed && source_a[WIDTH-1]) ? -source_a : source_a;
    assign mag_b     = (in_signed && source_b[WIDTH-1]) ? -source_b : source_b;

    assign alu_stall = start & (state_q != S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Sign fix-up and accumulate; divide-by-zero bypasses the sign fix entirely.
    always_comb begin
        prod_fix = neg_q ? -work_q : work_q;
        if (is_sub(op_q))      mul_res = acc_q - prod_fix;
        else if (is_acc(op_q)) mul_res = acc_q + prod_fix;
        else                   mul_res = prod_fix;
        quo = work_q[WIDTH-1:0];
        rem = work_q[2*WIDTH-1:WIDTH];
        if (!is_div(op_q)) begin
            fix_hi = mul_res[2*WIDTH-1:WIDTH];
            fix_lo = mul_res[WIDTH-1:0];
        end else if (b_q == '0) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            fix_hi = a_neg_q ? -rem : rem;
            fix_lo = neg_q ? -quo : quo;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        acc_d    = acc_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (hi_write) hi_d = hi_write_data;
                if (lo_write) lo_d = lo_write_data;
                if (start && !flush) begin
                    op_d    = op_in;
                    a_d     = source_a;
                    b_d     = source_b;
                    acc_d   = {hi_d, lo_d};
                    neg_d   = in_signed & (source_a[WIDTH-1] ^ source_b[WIDTH-1]);
                    a_neg_d = in_signed & source_a[WIDTH-1];
                    work_d  = '0;
                    mcand_d = '0;
                    if (is_div(op_in)) begin
                        work_d[WIDTH-1:0]  = mag_a;
                        mcand_d[WIDTH-1:0] = mag_b;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_DIV;
                    end else begin
                        mcand_d[WIDTH-1:0] = mag_a;
                        mplier_d = mag_b;
                        cnt_d    = CW'(WIDTH / STEP);
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    work_d   = step_work;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (hi_write) hi_d = hi_write_data;
                if (lo_write) lo_d = lo_write_data;
                if (flush || !reg_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            acc_q    <= '0;
            work_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
